pbit_sweep_scheduler: RTL and testbench
=======================================

# pbit_sweep_scheduler

Sequences asynchronous-style single-spin updates across the p-bit array of the probabilistic multiplier. It issues one one-hot update enable per p-bit slot, then holds all enables low for the settle cycles of that slot. Clamped p-bits (fixed multiplier inputs or outputs) are skipped. A host-programmed number of full sweeps is run under a start/done handshake. It sits between the host/sampler control logic and the p-bit array's per-bit update inputs.

## Interface
Parameters:
- `N`, 16: number of p-bits; legal range 2..64.
- `SLOT`, 3: cycles per update slot, made of 1 fire cycle and SLOT-1 settle cycles; must be ≥2.
- `SWEEP_W`, 16: width of the sweep count and sweep index.

Ports:
- `CLK` in 1: the single clock. All logic is on the rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `start` in 1: begin a run. Sampled only when `busy`=0.
- `num_sweeps` in SWEEP_W: number of sweeps. Latched at accepted start.
- `clamp_mask` in N: a 1 means that p-bit is clamped and skipped. Latched at accepted start.
- `hold` in 1: freezes sequencing while high.
- `upd_en` out N: one-hot update enable, or all zero.
- `busy` out 1: high from the cycle after an accepted start through the final sweep_done cycle.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.
- `sweep_idx` out SWEEP_W: number of completed sweeps. Cleared at accepted start.
- `done` out 1: one-cycle pulse at the end of the run.

## Operation
- States: IDLE, FIRE, SETTLE, SWEEP_END, FINISH.
- IDLE:
  - `start`=1 latches `num_sweeps` and `clamp_mask`, and clears `sweep_idx`.
  - If `num_sweeps`=0, go to FINISH.
  - Else if the latched mask is all ones, go to SWEEP_END.
  - Else set `idx` to the lowest unclamped bit and go to FIRE.
- FIRE:
  - `upd_en` = 1<<idx for exactly one cycle.
  - Go to SETTLE and load the settle counter with SLOT-1.
- SETTLE:
  - `upd_en`=0. The counter decrements each cycle.
  - On the last settle cycle, go to FIRE at the next higher unclamped index if one exists, else go to SWEEP_END.
- SWEEP_END:
  - `upd_en`=0, `sweep_done`=1, and `sweep_idx` increments on the same edge.
  - If `sweep_idx`+1 = `num_sweeps`, go to FINISH.
  - Else restart at the lowest unclamped bit (FIRE), or go to SWEEP_END again if the mask is all ones.
- FINISH: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Sweep length is U·SLOT+1 cycles, where U is the number of unclamped bits.
- Index order is strictly ascending within a sweep. Index wrap to the lowest unclamped bit happens only via SWEEP_END.
- `hold`:
  - While `hold`=1, the state, idx, settle counter and sweep counters are frozen.
  - `upd_en`, `sweep_done` and `done` are forced to 0.
  - A fire, sweep_done or done cycle that coincides with `hold` is deferred, not dropped. It is emitted in full on the first cycle with `hold`=0.
  - `hold` in IDLE has no effect on start acceptance.
- `start` while busy is ignored. Changes to `clamp_mask` or `num_sweeps` mid-run are ignored.
- Reset:
  - `RST_N`=0 at any edge forces IDLE, `upd_en`=0, `busy`=0, `sweep_done`=0, `done`=0 and `sweep_idx`=0. This applies mid-run too.
  - A new start is accepted on the first edge after reset is released.

## Timing
- An accepted start at edge E makes `busy`=1 and the first FIRE visible in the cycle after E (latency 1).
- Two consecutive unclamped bits fire exactly SLOT cycles apart. Clamped bits consume zero cycles.
- `upd_en` is never high on two bits at once. It is never high during SETTLE, SWEEP_END, FINISH or hold.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `pbit_sched_pkg` holds:
  - the state enum;
  - the default SLOT constant;
  - a helper giving the width of `idx` as clog2(N).
- Sub-module `pbit_next_index`: combinational priority finder.
  - Inputs: latched mask, current idx, a first/next select.
  - Outputs: the next unclamped index greater than idx (or the lowest one when first is selected), plus a `none` flag.
- The top module contains the FSM, settle counter, sweep counter and output registers.

## Test plan
In all scenarios N=16, SLOT=3, and start is accepted at edge 0; cycle k is the k-th cycle after that edge.
- mask=0x0000, sweeps=1 -> bit i fires at cycle 1+3i (bit 15 at cycle 46); `sweep_done` at cycle 49; `done` at cycle 50; `sweep_idx`=1.
- mask=0x00FF, sweeps=2 -> bits 8..15 fire at cycles 1, 4, …, 22; `sweep_done` at 25; bit 8 fires again at 26; second `sweep_done` at 50; `done` at 51; `sweep_idx`=2.
- Edge cases:
  - sweeps=0 -> `done` at cycle 1, `busy` never high, `upd_en` never nonzero.
  - mask=0xFFFF, sweeps=3 -> `sweep_done` at cycles 1, 2 and 3; `done` at cycle 4; no `upd_en`.
- mask=0, sweeps=1, `hold`=1 during cycles 4-6 -> bit 1 fires at cycle 7 instead of 4; every later event shifts by 3; `done` at cycle 53.
- `RST_N`=0 at cycle 10 mid-run -> all outputs 0 from cycle 11; `start` after release restarts at bit 0 with `sweep_idx`=0. Also: `start` pulsed at cycle 20 of a run -> ignored, timing unchanged.

Source files
------------

// File: rtl/pbit_sweep_scheduler_pkg.sv
// Shared types and constants for the p-bit sweep scheduler.
// Holds the FSM state encoding and the index-width helper.
package pbit_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRE      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SWEEP_END = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  localparam int DEFAULT_SLOT = 3;

  // Width needed to hold an index in 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbit_next_index.sv
// Combinational priority finder: lowest unclamped bit (first=1) or the
// lowest unclamped bit strictly above idx (first=0), with a none flag.
module pbit_next_index #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  input  logic          first,
  output logic [IW-1:0] nxt_idx,
  output logic          none
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt_idx = '0;
    none    = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!mask[i] && (first || (i > int'(idx)))) begin
        nxt_idx = IW'(i);
        none    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sweep scheduler: fires one unclamped p-bit per slot in ascending order,
// then settles, for a host-programmed number of sweeps.
module pbit_sweep_scheduler
  import pbit_sched_pkg::*;
#(
  parameter int N       = 16,
  parameter int SLOT    = DEFAULT_SLOT,
  parameter int SWEEP_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [N-1:0]       clamp_mask,
  input  logic               hold,
  output logic [N-1:0]       upd_en,
  output logic               busy,
  output logic               sweep_done,
  output logic [SWEEP_W-1:0] sweep_idx,
  output logic               done,
  output state_e             dbg_state
);

  localparam int IW = idx_width(N);
  localparam int CW = idx_width(SLOT);

  // Handshake: start is taken only in IDLE (busy=0); busy rises the next
  // cycle and stays high through the last sweep_done; done then pulses
  // once with busy low, and the block returns to IDLE.
  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SWEEP_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [SWEEP_W-1:0] num_q, num_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [N-1:0]       upd_en_q, upd_en_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               done_q, done_d;
  logic               frozen;

  logic [N-1:0]       ni_mask;
  logic               ni_first;
  logic [IW-1:0]      ni_idx;
  logic               ni_none;

  // In IDLE the incoming mask is searched so the first fire needs no extra cycle.
  assign ni_mask  = (state_q == ST_IDLE) ? clamp_mask : mask_q;
  assign ni_first = (state_q != ST_SETTLE);

  pbit_next_index #(.N(N), .IW(IW)) u_next (
    .mask    (ni_mask),
    .idx     (idx_q),
    .first   (ni_first),
    .nxt_idx (ni_idx),
    .none    (ni_none)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    sweep_idx_d = sweep_idx_q;
    num_d       = num_q;
    mask_d      = mask_q;
    frozen      = hold && (state_q != ST_IDLE);

    if (!frozen) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_d       = num_sweeps;
            mask_d      = clamp_mask;
            sweep_idx_d = '0;
            if (num_sweeps == '0) begin
              state_d = ST_FINISH;
            end else if (ni_none) begin
              state_d     = ST_SWEEP_END;
              sweep_idx_d = SWEEP_W'(1);
            end else begin
              state_d = ST_FIRE;
              idx_d   = ni_idx;
            end
          end
        end
        ST_FIRE: begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SLOT - 1);
        end
        ST_SETTLE: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (ni_none) begin
              state_d     = ST_SWEEP_END;
              sweep_idx_d = sweep_idx_q + SWEEP_W'(1);
            end else begin
              state_d = ST_FIRE;
              idx_d   = ni_idx;
            end
          end
        end
        ST_SWEEP_END: begin
          // sweep_idx_q already counts the sweep that just ended.
          if (sweep_idx_q == num_q) begin
            state_d = ST_FINISH;
          end else if (ni_none) begin
            state_d     = ST_SWEEP_END;
            sweep_idx_d = sweep_idx_q + SWEEP_W'(1);
          end else begin
            state_d = ST_FIRE;
            idx_d   = ni_idx;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // A frozen cycle keeps the state, so the pulse is emitted on the release edge.
    upd_en_d = '0;
    if (!frozen && (state_d == ST_FIRE)) upd_en_d = N'(1) << idx_d;
    sweep_done_d = !frozen && (state_d == ST_SWEEP_END);
    done_d       = !frozen && (state_d == ST_FINISH);
    busy_d       = (state_d == ST_FIRE) || (state_d == ST_SETTLE) ||
                   (state_d == ST_SWEEP_END);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      sweep_idx_q  <= '0;
      num_q        <= '0;
      mask_q       <= '0;
      upd_en_q     <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sweep_idx_q  <= sweep_idx_d;
      num_q        <= num_d;
      mask_q       <= mask_d;
      upd_en_q     <= upd_en_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      done_q       <= done_d;
    end
  end

  assign upd_en     = upd_en_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign sweep_idx  = sweep_idx_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Self-checking bench for pbit_sweep_scheduler (N=16, SLOT=3): a timeline
// model fills an event queue that a negedge scoreboard drains.
module tb_pbit_sweep_scheduler;
  import pbit_sched_pkg::*;

  localparam int N    = 16;
  localparam int SLOT = 3;
  localparam int SW   = 16;

  logic          CLK;
  logic          RST_N;
  logic          start;
  logic [SW-1:0] num_sweeps;
  logic [N-1:0]  clamp_mask;
  logic          hold;
  logic [N-1:0]  upd_en;
  logic          busy;
  logic          sweep_done;
  logic [SW-1:0] sweep_idx;
  logic          done;
  state_e        dbg_state;

  pbit_sweep_scheduler #(.N(N), .SLOT(SLOT), .SWEEP_W(SW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .num_sweeps (num_sweeps),
    .clamp_mask (clamp_mask),
    .hold       (hold),
    .upd_en     (upd_en),
    .busy       (busy),
    .sweep_done (sweep_done),
    .sweep_idx  (sweep_idx),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- scoreboard ----------------
  // Event word: {cycle[31:0], kind[1:0], value[29:0]}; kind 0=fire 1=sweep_done 2=done.
  logic [63:0] exp_q[$];
  int          cyc     = 0;
  bit          sb_on   = 1'b0;
  int          busy_lo = 1;
  int          busy_hi = 0;

  function automatic logic [63:0] ev(input int t, input int kind, input int val);
    return {32'(t), 2'(kind), 30'(val)};
  endfunction

  function automatic int sh(input int t, input int h0, input int hl);
    return (hl > 0 && t >= h0) ? t + hl : t;
  endfunction

  logic [63:0] sb_act[3];
  logic [63:0] sb_exp;
  int          sb_n;
  int          sb_bit;
  logic        sb_busy;

  always @(negedge CLK) begin
    if (sb_on) begin
      cyc = cyc + 1;
      sb_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      vectors++;
      if (busy !== sb_busy) begin
        miscompares++;
        $display("FAIL busy: cycle %0d got %0b expected %0b", cyc, busy, sb_busy);
      end
      sb_n = 0;
      if (upd_en !== '0) begin
        vectors++;
        if (!$onehot(upd_en)) begin
          miscompares++;
          $display("FAIL onehot: cycle %0d got upd_en=%h expected one bit set", cyc, upd_en);
        end
        sb_bit = 0;
        for (int i = 0; i < N; i++) if (upd_en[i]) sb_bit = i;
        sb_act[sb_n] = ev(cyc, 0, sb_bit);
        sb_n++;
      end
      if (sweep_done === 1'b1) begin
        sb_act[sb_n] = ev(cyc, 1, int'(sweep_idx));
        sb_n++;
      end
      if (done === 1'b1) begin
        sb_act[sb_n] = ev(cyc, 2, int'(sweep_idx));
        sb_n++;
      end
      for (int j = 0; j < sb_n; j++) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL event_extra: got cyc=%0d kind=%0d val=%0d expected none",
                   sb_act[j][63:32], sb_act[j][31:30], sb_act[j][29:0]);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_act[j] !== sb_exp) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                     sb_act[j][63:32], sb_act[j][31:30], sb_act[j][29:0],
                     sb_exp[63:32], sb_exp[31:30], sb_exp[29:0]);
          end
        end
      end
    end
  end

  // ---------------- reference timeline ----------------
  // Events visible at cycle >= h0 are pushed back by the hold length; only
  // events up to cycle 'cut' are expected (used when reset aborts a run).
  task automatic model(input logic [N-1:0] mask, input int sweeps, input int h0,
                       input int h1, input int cut, output int done_t);
    int t;
    int hl;
    hl = (h0 > 0) ? (h1 - h0 + 1) : 0;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    t = 1;
    for (int s = 0; s < sweeps; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!mask[i]) begin
          if (sh(t, h0, hl) <= cut) exp_q.push_back(ev(sh(t, h0, hl), 0, i));
          t += SLOT;
        end
      end
      if (sh(t, h0, hl) <= cut) exp_q.push_back(ev(sh(t, h0, hl), 1, s + 1));
      busy_hi = sh(t, h0, hl);
      t += 1;
    end
    done_t = sh(t, h0, hl);
    if (done_t <= cut) exp_q.push_back(ev(done_t, 2, sweeps));
    if (busy_hi > cut) busy_hi = cut;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [N-1:0] mask, input int sweeps);
    clamp_mask = mask;
    num_sweeps = SW'(sweeps);
    RST_N      = 1'b1;
    start      = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    cyc   = 0;
    sb_on = 1'b1;
  endtask

  // Inputs set in loop pass k are sampled at edge k.
  task automatic drive_run(input int len, input int h0, input int h1,
                           input int sp, input int rst_k);
    for (int k = 1; k <= len; k++) begin
      hold  = (h0 > 0) && (k >= h0 - 1) && (k <= h1 - 1);
      start = (k == sp);
      if (k == sp) begin
        clamp_mask = 16'hFFFF;
        num_sweeps = 16'd7;
      end
      RST_N = !((rst_k > 0) && (k >= rst_k));
      @(posedge CLK);
      #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    sb_on = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST_N = 1'b0; start = 1'b1; hold = 1'b0;
    clamp_mask = '0; num_sweeps = 16'd1;
    repeat (3) @(posedge CLK);
    #1;
    start = 1'b0;
    vectors++; if (upd_en !== '0) begin miscompares++; $display("FAIL rst_upd_en: got %h expected 0", upd_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL rst_sweep_done: got %b expected 0", sweep_done); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    vectors++; if (sweep_idx !== '0) begin miscompares++; $display("FAIL rst_sweep_idx: got %0d expected 0", sweep_idx); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_full_sweep;
    int dt;
    model(16'h0000, 1, 0, 0, 100000, dt);
    start_run(16'h0000, 1);
    drive_run(dt + 2, 0, 0, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd1) begin miscompares++; $display("FAIL full_sweep_idx: got %0d expected 1", sweep_idx); end
  endtask

  task automatic test_half_mask;
    int dt;
    model(16'h00FF, 2, 0, 0, 100000, dt);
    start_run(16'h00FF, 2);
    drive_run(dt + 2, 0, 0, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL half_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd2) begin miscompares++; $display("FAIL half_sweep_idx: got %0d expected 2", sweep_idx); end
  endtask

  task automatic test_zero_sweeps;
    int dt;
    model(16'h1234, 0, 0, 0, 100000, dt);
    start_run(16'h1234, 0);
    drive_run(dt + 4, 0, 0, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL zero_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd0) begin miscompares++; $display("FAIL zero_sweep_idx: got %0d expected 0", sweep_idx); end
  endtask

  task automatic test_all_clamped;
    int dt;
    model(16'hFFFF, 3, 0, 0, 100000, dt);
    start_run(16'hFFFF, 3);
    drive_run(dt + 2, 0, 0, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL clamp_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd3) begin miscompares++; $display("FAIL clamp_sweep_idx: got %0d expected 3", sweep_idx); end
  endtask

  task automatic test_hold;
    int dt;
    model(16'h0000, 1, 4, 6, 100000, dt);
    start_run(16'h0000, 1);
    drive_run(dt + 2, 4, 6, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL hold_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd1) begin miscompares++; $display("FAIL hold_sweep_idx: got %0d expected 1", sweep_idx); end
  endtask

  task automatic test_mid_reset;
    int dt;
    model(16'h0000, 1, 0, 0, 10, dt);
    start_run(16'h0000, 1);
    drive_run(12, 0, 0, 0, 10);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mrst_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd0) begin miscompares++; $display("FAIL mrst_sweep_idx: got %0d expected 0", sweep_idx); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL mrst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    // Start on the same edge that first sees reset released.
    model(16'h0000, 1, 0, 0, 100000, dt);
    start_run(16'h0000, 1);
    drive_run(dt + 2, 0, 0, 0, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mrst_restart_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd1) begin miscompares++; $display("FAIL mrst_restart_idx: got %0d expected 1", sweep_idx); end
  endtask

  task automatic test_start_ignored;
    int dt;
    model(16'h0000, 1, 0, 0, 100000, dt);
    start_run(16'h0000, 1);
    drive_run(dt + 2, 0, 0, 20, 0);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL busy_start_missing: got %0d left expected 0", exp_q.size()); end
    vectors++; if (sweep_idx !== 16'd1) begin miscompares++; $display("FAIL busy_start_idx: got %0d expected 1", sweep_idx); end
  endtask

  task automatic test_back_to_back;
    int dt;
    int sw;
    int h0;
    int h1;
    logic [N-1:0] m;
    for (int it = 0; it < 8; it++) begin
      m  = N'($urandom_range(0, 16'hFFFF));
      if (it == 2) m = 16'hFFFF;
      if (it == 3) m = 16'h8000;
      sw = $urandom_range(0, 3);
      h0 = 0;
      h1 = 0;
      if (it % 2 == 1) begin
        h0 = $urandom_range(2, 30);
        h1 = h0 + $urandom_range(0, 3);
      end
      model(m, sw, h0, h1, 100000, dt);
      start_run(m, sw);
      drive_run(dt + (h1 - h0 + 1) + 2, h0, h1, 0, 0);
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_missing: iter %0d got %0d left expected 0", it, exp_q.size()); end
      vectors++; if (sweep_idx !== SW'(sw)) begin miscompares++; $display("FAIL b2b_sweep_idx: iter %0d got %0d expected %0d", it, sweep_idx, sw); end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_half_mask();
    test_zero_sweeps();
    test_all_clamped();
    test_hold();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
